// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 3-stage core pipeline control.
// Opcode and branch-type encodings are used by the DE-stage condition unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } ctrl_state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef struct packed {
    logic pc_sel;
    logic flush_de;
    logic stall;
    logic fwd_a;
    logic fwd_b;
  } hz_ctrl_t;

  // x0 is hardwired to zero, so it never takes forwarded data
  function automatic logic fwd_hit(
    input logic       valid,
    input logic       wr_en,
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return valid & wr_en & (rd != 5'd0) & (rd == rs);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Redirect, flush, stall and forwarding control for the IF | DE | MW core.
// Memory stalls are timed by a RUN/WAIT/ERR FSM; ERR is left only by reset.
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_taken,
  input  logic              de_valid,
  input  logic [4:0]        de_rs1,
  input  logic [4:0]        de_rs2,
  input  logic              mw_valid,
  input  logic [4:0]        mw_rd,
  input  logic              mw_wr_en,
  input  logic              mw_mem_req,
  input  logic              dmem_ready,
  output logic              pc_sel,
  output logic              flush_de,
  output logic              stall,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              mem_err,
  output logic [PERF_W-1:0] perf_br,
  output logic [PERF_W-1:0] perf_stall
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  ctrl_state_e      state_q;
  ctrl_state_e      state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             mem_err_q;
  logic             mem_err_d;

  logic             mem_busy;
  hz_ctrl_t         hz;
  logic [PERF_W-1:0] perf_br_raw;
  logic [PERF_W-1:0] perf_stall_raw;

  assign mem_busy = mw_valid & mw_mem_req & ~dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!mem_busy) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TO_CNT) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign mem_err_d = mem_err_q | (state_d == ERR);

  // A branch held in DE by a stall redirects in the first unstalled cycle
  always_comb begin
    hz          = '0;
    hz.stall    = mem_busy | (state_q == ERR);
    hz.pc_sel   = br_taken & de_valid & ~hz.stall;
    hz.flush_de = hz.pc_sel;
    hz.fwd_a    = fwd_hit(mw_valid, mw_wr_en, mw_rd, de_rs1);
    hz.fwd_b    = fwd_hit(mw_valid, mw_wr_en, mw_rd, de_rs2);
  end

  sat_counter #(
    .W(PERF_W)
  ) u_perf_br (
    .clk (clk),
    .en  (hz.flush_de),
    .clr (rst),
    .q   (perf_br_raw)
  );

  sat_counter #(
    .W(PERF_W)
  ) u_perf_stall (
    .clk (clk),
    .en  (hz.stall),
    .clr (rst),
    .q   (perf_stall_raw)
  );

  always_comb begin
    pc_sel     = 1'b0;
    flush_de   = 1'b0;
    stall      = 1'b0;
    fwd_a      = 1'b0;
    fwd_b      = 1'b0;
    mem_err    = 1'b0;
    perf_br    = '0;
    perf_stall = '0;
    if (!rst) begin
      pc_sel     = hz.pc_sel;
      flush_de   = hz.flush_de;
      stall      = hz.stall;
      fwd_a      = hz.fwd_a;
      fwd_b      = hz.fwd_b;
      mem_err    = mem_err_q;
      perf_br    = perf_br_raw;
      perf_stall = perf_stall_raw;
    end
  end

endmodule
